clkdiv_multi: RTL and testbench
===============================

CLKDIV_MULTI -- requirements
Module: clkdiv_multi

Interface
REQ-001 Parameter NCH, default 4: number of independent divider channels, range 1..16.
REQ-002 Parameter WIDTH, default 32: width of the phase-length counters and registers.
REQ-003 Parameter AW, default 2: channel address width, with 2^AW >= NCH.
REQ-004 Parameter RST_HALF, default 0: reset value of every HI and LO register.
REQ-005 CLK  input  1  system clock; one clock, 100 MHz crystal oscillator.
REQ-006 RSTN  input  1  reset, asynchronous and active-low.
REQ-007 en  input  NCH  per-channel run enable, level-sensitive.
REQ-008 wr_en  input  1  single-cycle write strobe for the configuration registers.
REQ-009 wr_addr  input  AW  channel index for the write.
REQ-010 wr_hi  input  WIDTH  high-phase length minus 1.
REQ-011 wr_lo  input  WIDTH  low-phase length minus 1.
REQ-012 clk_out  output  NCH  divided clock level per channel, registered.
REQ-013 tick  output  NCH  one-CLK pulse per channel, coincident with the first cycle clk_out is high.
REQ-014 pend  output  NCH  per channel, 1 = written values are waiting to become active.

Function
REQ-015 Each channel SHALL hold pending HI_P/LO_P, active HI_A/LO_A, a WIDTH-bit counter cnt and a phase bit.
REQ-016 The channel state machine SHALL have three states: OFF (en=0), LOW (clk_out=0) and HIGH (clk_out=1).
REQ-017 LOW behaviour: if cnt==LO_A, go to HIGH, clear cnt and assert tick for that one cycle; otherwise increment cnt.
REQ-018 HIGH behaviour: if cnt==HI_A, go to LOW and clear cnt; otherwise increment cnt.
REQ-019 Resulting timing: low phase = LO_A+1 CLK cycles, high phase = HI_A+1 cycles, period = HI_A+LO_A+2 cycles; HI=LO=0 SHALL give CLK/2.
REQ-020 Counter compares SHALL be exact equality on WIDTH bits, with no wrap; all-ones values SHALL be legal.
REQ-021 Write: a wr_en with wr_addr<NCH SHALL load HI_P/LO_P on that edge and set pend.
REQ-022 A write with wr_addr>=NCH SHALL be ignored.
REQ-023 Active update: HI_P/LO_P SHALL copy to HI_A/LO_A only at the LOW-to-HIGH transition or while in OFF; pend SHALL then clear.
REQ-024 A write on the same edge as an active update SHALL land in pending: the old pending values are copied to active, and pend stays 1.
REQ-025 A period in progress SHALL never change length, so the output stays glitch-free.
REQ-026 en falling: on the next CLK edge enter OFF, force clk_out=0, tick=0 and cnt=0.
REQ-027 en rising: the channel SHALL start in LOW with cnt=0; the first tick occurs LO_A+1 cycles after en is sampled high.
REQ-028 Channels SHALL be fully independent; one write SHALL affect only the addressed channel.

Reset
REQ-029 While RSTN=0: clk_out=0, tick=0, pend=0, cnt=0, state OFF, and HI_P/LO_P/HI_A/LO_A=RST_HALF.
REQ-030 Reset mid-period SHALL take effect immediately and asynchronously.
REQ-031 After RSTN deasserts, channels with en=1 SHALL start in LOW with cnt=0.

Configuration
REQ-032 Macro CLKDIV_SYNC_EN defined: add input sync (1 bit).
REQ-033 A sync pulse SHALL move every enabled channel to LOW with cnt=0, clk_out=0 and tick=0, and load pending into active, so all channels restart phase-aligned.
REQ-034 sync SHALL take priority over the REQ-017/018 transitions and over en rising in the same cycle.
REQ-035 Macro CLKDIV_SYNC_EN undefined: the sync port SHALL be absent and behaviour is as REQ-015..031 only.

Verification
REQ-036 Reset, en=1, HI=LO=0 -> clk_out toggles every CLK; tick on every second cycle.
REQ-037 Ch0 HI=2 LO=4 -> clk_out low 5 cycles then high 3, period 8; tick on the first high cycle.
REQ-038 Write ch1 HI=LO=9 mid-high-phase -> current period unchanged; pend[1]=1 until the next rising edge, then period 20 and pend clears.
REQ-039 Write wr_addr=NCH -> no register, pend or output change on any channel.
REQ-040 Drop en mid-high-phase, then re-raise -> clk_out=0 the next cycle; after re-raise, first tick at LO_A+1 cycles.
REQ-041 (CLKDIV_SYNC_EN) Ch0 HI=LO=1 and ch1 HI=LO=3 free-running, pulse sync -> both clk_out low; first rising edges 2 and 4 cycles later; sync coincident with a tick suppresses that tick.

Source files
------------

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider; new HI/LO settings take effect only at a period boundary.
// Optional feature macro CLKDIV_SYNC_EN adds a sync input that restarts all enabled channels in phase.
module clkdiv_multi #(
    parameter int unsigned      NCH      = 4,
    parameter int unsigned      WIDTH    = 32,
    parameter int unsigned      AW       = 2,
    parameter logic [WIDTH-1:0] RST_HALF = '0
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic [NCH-1:0]   en,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_hi,
    input  logic [WIDTH-1:0] wr_lo,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pend
);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } state_t;

    logic resync;
`ifdef CLKDIV_SYNC_EN
    assign resync = sync;
`else
    assign resync = 1'b0;
`endif

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        state_t           state;
        logic [WIDTH-1:0] hi_p;
        logic [WIDTH-1:0] lo_p;
        logic [WIDTH-1:0] hi_a;
        logic [WIDTH-1:0] lo_a;
        logic [WIDTH-1:0] cnt;
        logic             out_q;
        logic             tick_q;
        logic             pend_q;
        logic             wr_hit;
        logic             load;

        // Addresses at or above NCH match no channel and are dropped.
        assign wr_hit = wr_en && (wr_addr == AW'(i));

        // Pending values become active while idle, on a resync, or at the start of a high phase.
        assign load = (state == ST_OFF) ||
                      (en[i] && (resync || ((state == ST_LOW) && (cnt == lo_a))));

        always_ff @(posedge CLK or negedge RSTN) begin
            if (!RSTN) begin
                state  <= ST_OFF;
                hi_p   <= RST_HALF;
                lo_p   <= RST_HALF;
                hi_a   <= RST_HALF;
                lo_a   <= RST_HALF;
                cnt    <= '0;
                out_q  <= 1'b0;
                tick_q <= 1'b0;
                pend_q <= 1'b0;
            end else begin
                if (wr_hit) begin
                    hi_p <= wr_hi;
                    lo_p <= wr_lo;
                end
                if (load) begin
                    hi_a <= hi_p;
                    lo_a <= lo_p;
                end
                // A write landing on an update edge stays pending for the next boundary.
                pend_q <= wr_hit | (pend_q & ~load);
                tick_q <= 1'b0;

                if (!en[i]) begin
                    state <= ST_OFF;
                    out_q <= 1'b0;
                    cnt   <= '0;
                end else if (resync || (state == ST_OFF)) begin
                    state <= ST_LOW;
                    out_q <= 1'b0;
                    cnt   <= '0;
                end else if (state == ST_LOW) begin
                    if (cnt == lo_a) begin
                        state  <= ST_HIGH;
                        out_q  <= 1'b1;
                        tick_q <= 1'b1;
                        cnt    <= '0;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end else begin
                    if (cnt == hi_a) begin
                        state <= ST_LOW;
                        out_q <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + WIDTH'(1);
                    end
                end
            end
        end

        assign clk_out[i] = out_q;
        assign tick[i]    = tick_q;
        assign pend[i]    = pend_q;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// Scoreboard bench for clkdiv_multi: expected per-cycle channel outputs are queued as stimulus is
// driven (derived from the LO+1 / HI+1 phase lengths) and compared after every clock edge.
module tb_clkdiv_multi;
    localparam int unsigned NCH   = 3;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned AW    = 2;

    typedef struct packed {
        logic [NCH-1:0] mask;
        logic [NCH-1:0] clk;
        logic [NCH-1:0] tk;
        logic [NCH-1:0] pd;
    } exp_t;

    logic             CLK;
    logic             RSTN;
    logic [NCH-1:0]   en;
    logic             wr_en;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_hi;
    logic [WIDTH-1:0] wr_lo;
`ifdef CLKDIV_SYNC_EN
    logic             sync;
`endif
    logic [NCH-1:0]   clk_out;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   pend;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;

    clkdiv_multi #(
        .NCH     (NCH),
        .WIDTH   (WIDTH),
        .AW      (AW),
        .RST_HALF(8'h00)
    ) dut (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .en     (en),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_hi  (wr_hi),
        .wr_lo  (wr_lo),
`ifdef CLKDIV_SYNC_EN
        .sync   (sync),
`endif
        .clk_out(clk_out),
        .tick   (tick),
        .pend   (pend)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_exp(input int j, input int ch, input logic c, input logic t, input logic p);
        exp_t e;
        while (exp_q.size() <= j) exp_q.push_back('0);
        e          = exp_q[j];
        e.mask[ch] = 1'b1;
        e.clk[ch]  = c;
        e.tk[ch]   = t;
        e.pd[ch]   = p;
        exp_q[j]   = e;
    endtask

    task automatic set_const(input int j0, input int ch, input int n,
                             input logic c, input logic t, input logic p);
        for (int k = 0; k < n; k++) set_exp(j0 + k, ch, c, t, p);
    endtask

    // off = position in the LO+1 low / HI+1 high period at the first queued edge (0 = first low cycle).
    task automatic set_wave(input int j0, input int ch, input int lo, input int hi,
                            input int off, input int n, input logic p);
        int per;
        int pos;
        per = lo + hi + 2;
        for (int k = 0; k < n; k++) begin
            pos = (off + k) % per;
            set_exp(j0 + k, ch, pos >= lo + 1, pos == lo + 1, p);
        end
    endtask

    task automatic run(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            cyc++;
            wr_en = 1'b0;
`ifdef CLKDIV_SYNC_EN
            sync = 1'b0;
`endif
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                for (int ch = 0; ch < int'(NCH); ch++) begin
                    if (e.mask[ch]) begin
                        check($sformatf("clk_out[%0d]@%0d", ch, cyc), 32'(clk_out[ch]), 32'(e.clk[ch]));
                        check($sformatf("tick[%0d]@%0d", ch, cyc), 32'(tick[ch]), 32'(e.tk[ch]));
                        check($sformatf("pend[%0d]@%0d", ch, cyc), 32'(pend[ch]), 32'(e.pd[ch]));
                    end
                end
            end
        end
    endtask

    task automatic wr(input int a, input int hi, input int lo);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_hi   = WIDTH'(hi);
        wr_lo   = WIDTH'(lo);
    endtask

    initial begin
        RSTN    = 1'b0;
        en      = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_hi   = '0;
        wr_lo   = '0;
`ifdef CLKDIV_SYNC_EN
        sync    = 1'b0;
`endif
        run(2);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        RSTN = 1'b1;

        // HI=LO=0 on ch0: divide by two.
        wr(0, 0, 0);
        set_const(0, 0, 1, 1'b0, 1'b0, 1'b1);
        set_const(1, 0, 1, 1'b0, 1'b0, 1'b0);
        run(2);
        en[0] = 1'b1;
        set_wave(0, 0, 0, 0, 0, 8, 1'b0);
        run(8);

        // Ch0 HI=2 LO=4: period 8.
        en[0] = 1'b0;
        set_const(0, 0, 1, 1'b0, 1'b0, 1'b0);
        run(1);
        wr(0, 2, 4);
        set_const(0, 0, 1, 1'b0, 1'b0, 1'b1);
        set_const(1, 0, 1, 1'b0, 1'b0, 1'b0);
        run(2);
        en[0] = 1'b1;
        set_wave(0, 0, 4, 2, 0, 16, 1'b0);
        run(16);

        // Out-of-range address touches nothing.
        wr(3, 5, 5);
        set_wave(0, 0, 4, 2, 0, 8, 1'b0);
        set_const(0, 1, 8, 1'b0, 1'b0, 1'b0);
        set_const(0, 2, 8, 1'b0, 1'b0, 1'b0);
        run(8);

        // Drop en in the high phase, then re-raise.
        set_wave(0, 0, 4, 2, 0, 7, 1'b0);
        run(7);
        en[0] = 1'b0;
        set_const(0, 0, 3, 1'b0, 1'b0, 1'b0);
        run(3);
        en[0] = 1'b1;
        set_wave(0, 0, 4, 2, 0, 12, 1'b0);
        run(12);

        // Ch1 rewritten mid-high-phase; ch0 idle and untouched.
        en[0] = 1'b0;
        set_const(0, 0, 1, 1'b0, 1'b0, 1'b0);
        run(1);
        wr(1, 1, 1);
        set_const(0, 1, 1, 1'b0, 1'b0, 1'b1);
        set_const(1, 1, 1, 1'b0, 1'b0, 1'b0);
        set_const(0, 0, 2, 1'b0, 1'b0, 1'b0);
        run(2);
        en[1] = 1'b1;
        set_wave(0, 1, 1, 1, 0, 7, 1'b0);
        set_const(0, 0, 7, 1'b0, 1'b0, 1'b0);
        run(7);
        wr(1, 9, 9);
        set_wave(0, 1, 1, 1, 3, 3, 1'b1);
        set_wave(3, 1, 9, 9, 10, 41, 1'b0);
        set_const(0, 0, 44, 1'b0, 1'b0, 1'b0);
        run(44);

        // All-ones low phase on ch2: no wrap.
        en[1] = 1'b0;
        wr(2, 0, 255);
        set_const(0, 2, 1, 1'b0, 1'b0, 1'b1);
        set_const(1, 2, 1, 1'b0, 1'b0, 1'b0);
        run(2);
        en[2] = 1'b1;
        set_wave(0, 2, 255, 0, 0, 257, 1'b0);
        run(257);

        // Asynchronous reset while ch2 is high.
        RSTN = 1'b0;
        #2;
        check("async_rst_clk_out", 32'(clk_out), 32'd0);
        check("async_rst_tick", 32'(tick), 32'd0);
        run(1);
        check("rst_hold_pend", 32'(pend), 32'd0);
        RSTN = 1'b1;
        set_wave(0, 2, 0, 0, 0, 6, 1'b0);
        run(6);
        en[2] = 1'b0;
        run(1);

`ifdef CLKDIV_SYNC_EN
        // Sync realigns ch0 (HI=LO=1) and ch1 (HI=LO=3), suppressing ch0's due tick.
        wr(0, 1, 1);
        run(1);
        wr(1, 3, 3);
        run(3);
        en[0] = 1'b1;
        set_wave(0, 0, 1, 1, 0, 3, 1'b0);
        run(3);
        en[1] = 1'b1;
        set_wave(0, 0, 1, 1, 3, 3, 1'b0);
        set_wave(0, 1, 3, 3, 0, 3, 1'b0);
        run(3);
        sync = 1'b1;
        set_wave(0, 0, 1, 1, 0, 8, 1'b0);
        set_wave(0, 1, 3, 3, 0, 8, 1'b0);
        run(8);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
